// File: rtl/msdf_pkg.sv
// Shared MSDF definitions: signed-digit encoding and on-the-fly converter states.
// The multiplier datapath imports the same digit constants.
package msdf_pkg;

    localparam logic [1:0] DIGIT_POS  = 2'b10;
    localparam logic [1:0] DIGIT_NEG  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } otf_state_e;

endpackage

// File: rtl/msdf_otf_converter_if.sv
// Digit stream in, converted fraction out, for the MSDF on-the-fly converter.
interface msdf_otf_converter_if #(
    parameter int N = 9
);
    logic [1:0] z_digit;
    logic       z_valid;
    logic       flush;
    logic [N:0] result;
    logic       result_valid;
    logic       busy;

    modport master (
        output z_digit, z_valid, flush,
        input  result, result_valid, busy
    );

    modport slave (
        input  z_digit, z_valid, flush,
        output result, result_valid, busy
    );
endinterface

// File: rtl/otf_digit_append.sv
// Appends one signed digit to the Q/QM pair; QM tracks Q - 1 ulp so that
// a negative digit never needs a borrow chain.
module otf_digit_append
    import msdf_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N:0] q,
    input  logic [N:0] qm,
    input  logic [1:0] digit,
    output logic [N:0] q_next,
    output logic [N:0] qm_next
);

    always_comb begin
        q_next  = {q[N-1:0], 1'b0};
        qm_next = {qm[N-1:0], 1'b1};
        unique case (digit)
            DIGIT_POS: begin
                q_next  = {q[N-1:0], 1'b1};
                qm_next = {q[N-1:0], 1'b0};
            end
            DIGIT_NEG: begin
                q_next  = {qm[N-1:0], 1'b1};
                qm_next = {qm[N-1:0], 1'b0};
            end
            default: ;  // zero and the unused 2'b11 code both append a 0 digit
        endcase
    end

endmodule

// File: rtl/msdf_otf_converter.sv
// On-the-fly conversion of an N-digit MSDF signed-digit product into an
// (N+1)-bit two's-complement fraction.
//
//   state | meaning
//   IDLE  | no digits held, Q/QM at initial values, cnt = 0
//   CONV  | 1..N-1 digits of the current product absorbed into Q/QM
module msdf_otf_converter
    import msdf_pkg::*;
#(
    parameter int N = 9
) (
    input logic                 clk,
    input logic                 rst,
    msdf_otf_converter_if.slave bus
);

    localparam int             CW       = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

    otf_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic [N:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic [N:0]    q_app, qm_app;

    otf_digit_append #(.N(N)) u_append (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (bus.z_digit),
        .q_next  (q_app),
        .qm_next (qm_app)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            q_q            <= '0;
            qm_q           <= '1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            q_q            <= q_d;
            qm_q           <= qm_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        q_d            = q_q;
        qm_d           = qm_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            q_d     = '0;
            qm_d    = '1;
        end else if (bus.z_valid) begin
            // cnt is 0 in IDLE, so this also covers N = 1 completing from IDLE
            if (cnt_q == LAST_CNT) begin
                result_d       = q_app;
                result_valid_d = 1'b1;
                state_d        = IDLE;
                cnt_d          = '0;
                q_d            = '0;
                qm_d           = '1;
            end else begin
                state_d = CONV;
                cnt_d   = cnt_q + 1'b1;
                q_d     = q_app;
                qm_d    = qm_app;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q == CONV);

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Randomised and directed bench for msdf_otf_converter against an arithmetic
// model: the product is the weighted sum of digit values, wrapped to N+1 bits.
module tb_msdf_otf_converter;

    localparam int N = 9;

    logic clk;
    logic rst;

    msdf_otf_converter_if #(.N(N)) bus ();

    msdf_otf_converter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    string      phase;

    int         m_val;
    int         m_cnt;
    logic [N:0] m_res;
    logic       m_pulse;
    logic       m_busy;

    logic [1:0] digs [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic int dval(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        m_val   = 0;
        m_cnt   = 0;
        m_busy  = 1'b0;
        m_pulse = 1'b0;
    endtask

    // Entered at a falling edge; applies one cycle and checks all outputs.
    task automatic cycle(input logic v, input logic [1:0] d, input logic f);
        bus.z_valid = v;
        bus.z_digit = d;
        bus.flush   = f;
        @(posedge clk);
        m_pulse = 1'b0;
        if (f) begin
            model_reset();
        end else if (v) begin
            m_val = m_val * 2 + dval(d);
            m_cnt++;
            if (m_cnt == N) begin
                m_res   = m_val[N:0];
                m_pulse = 1'b1;
                m_val   = 0;
                m_cnt   = 0;
                m_busy  = 1'b0;
            end else begin
                m_busy = 1'b1;
            end
        end
        @(negedge clk);
        chk("result_valid", 32'(bus.result_valid), 32'(m_pulse));
        chk("result", 32'(bus.result), 32'(m_res));
        chk("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 2'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic run_op(input int max_gap, input int n_digits);
        for (int i = 0; i < n_digits; i++) begin
            idle_cycles($urandom_range(0, max_gap));
            cycle(1'b1, digs[i], 1'b0);
        end
    endtask

    task automatic fill(input logic [1:0] first, input logic [1:0] second, input logic [1:0] rest);
        digs[0] = first;
        digs[1] = second;
        for (int i = 2; i < N; i++) digs[i] = rest;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_res = '0;
        model_reset();
        rst         = 1'b0;
        bus.z_valid = 1'b0;
        bus.z_digit = 2'b00;
        bus.flush   = 1'b0;

        phase = "reset";
        repeat (2) @(negedge clk);
        chk("result", 32'(bus.result), 32'h0);
        chk("result_valid", 32'(bus.result_valid), 32'h0);
        chk("busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;

        phase = "all_pos";
        fill(2'b10, 2'b10, 2'b10);
        run_op(0, N);
        chk("expect_1ff", 32'(m_res), 32'h1FF);
        idle_cycles(2);

        phase = "all_neg";
        fill(2'b01, 2'b01, 2'b01);
        run_op(0, N);
        chk("expect_201", 32'(m_res), 32'h201);

        phase = "pos_neg_zero";
        fill(2'b10, 2'b01, 2'b00);
        run_op(0, N);
        chk("expect_080", 32'(m_res), 32'h080);

        phase = "neg_then_pos";
        fill(2'b01, 2'b10, 2'b10);
        run_op(0, N);
        chk("expect_3ff", 32'(m_res), 32'h3FF);

        phase = "gapped";
        fill(2'b10, 2'b01, 2'b00);
        run_op(3, N);
        chk("expect_080_gap", 32'(m_res), 32'h080);

        phase = "code_11";
        fill(2'b10, 2'b01, 2'b11);
        run_op(2, N);
        chk("expect_080_11", 32'(m_res), 32'h080);

        phase = "back_to_back";
        fill(2'b10, 2'b10, 2'b10);
        run_op(0, N);
        fill(2'b01, 2'b01, 2'b01);
        run_op(0, N);
        chk("expect_201_b2b", 32'(m_res), 32'h201);

        phase = "flush";
        fill(2'b01, 2'b10, 2'b00);
        run_op(1, 4);
        cycle(1'b1, 2'b10, 1'b1);
        fill(2'b10, 2'b10, 2'b10);
        run_op(0, N);
        chk("expect_1ff_flush", 32'(m_res), 32'h1FF);

        phase = "async_reset";
        fill(2'b10, 2'b01, 2'b10);
        run_op(0, 5);
        #2;
        rst = 1'b0;
        #1;
        m_res = '0;
        model_reset();
        chk("result", 32'(bus.result), 32'h0);
        chk("result_valid", 32'(bus.result_valid), 32'h0);
        chk("busy", 32'(bus.busy), 32'h0);
        bus.z_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fill(2'b01, 2'b01, 2'b01);
        run_op(0, N);
        chk("expect_201_rst", 32'(m_res), 32'h201);

        phase = "random";
        for (int op = 0; op < 40; op++) begin
            for (int i = 0; i < N; i++) digs[i] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                run_op(2, $urandom_range(1, N - 1));
                cycle($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 1'b1);
            end
            run_op($urandom_range(0, 1) * 3, N);
        end
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
